// File: rtl/replay_buffer_param.sv
// replay_buffer_param
//   Write-once / read-many operand buffer. Wide lines are written once per
//   job. Narrow words are then streamed out, cycling over the job's N words
//   a configurable number of times. Reads may start before all lines are
//   written: the first pass stalls (rd_empty_o) on lines not yet written.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start_i            1-cycle pulse: latch cfg_*_i and (re)start a job
//   cfg_rows_i/cols_i  job size factors, N = rows*cols words
//   cfg_repeat_i       passes over the N words (0 behaves as 1)
//   wr_data_i/valid_i  line offered; accepted when wr_valid_i && wr_ready_o
//   wr_ready_o         line can be accepted this cycle
//   rd_req_i           pop one word; ignored while rd_empty_o
//   rd_empty_o         next word not yet written, or no job running
//   rd_valid_o/data_o  word output, 2 cycles after the accepted rd_req_i
//   rd_last_o          marks the final word of the final pass
//   busy_o, done_o     job in progress / 1-cycle pulse with rd_last_o
//   cfg_err_o          sticky until next start: N==0 or too many lines
//   state_o            FSM state, for debug and checkers
//
// Handshake: a write transfers on every rising edge where wr_valid_i and
// wr_ready_o are both high. A read is accepted on every rising edge where
// rd_req_i is high, rd_empty_o is low and start_i is low. A start_i pulse
// takes priority over both: wr_ready_o is forced low while start_i is high.
module replay_buffer_param #(
  parameter int WR_W  = 1024,
  parameter int RD_W  = 32,
  parameter int DEPTH = 512,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cfg_rows_i,
  input  logic [CNT_W-1:0] cfg_cols_i,
  input  logic [CNT_W-1:0] cfg_repeat_i,
  input  logic [WR_W-1:0]  wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic             rd_req_i,
  output logic             rd_empty_o,
  output logic             rd_valid_o,
  output logic [RD_W-1:0]  rd_data_o,
  output logic             rd_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o,
  output logic [1:0]       state_o
);

  localparam int R   = WR_W / RD_W;
  localparam int RSH = $clog2(R);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = 2 * CNT_W;

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_RUN, S_ERR} state_t;

  state_t           state_q, state_d;
  logic             cfg_step_q;
  logic [CNT_W-1:0] rows_q, cols_q, rep_q, pass_q;
  logic [PW-1:0]    prod_q, lines_q, last_idx_q, ridx_q;
  logic [AW:0]      wcnt_q;
  logic             cfg_err_q;

  logic             s1_valid_q, s1_last_q;
  logic [RSH-1:0]   s1_word_q;
  logic [WR_W-1:0]  rd_line_q;
  logic             rd_valid_q, rd_last_q, done_q;
  logic [RD_W-1:0]  rd_data_q;

  logic [WR_W-1:0]  mem [DEPTH];

  logic [PW-1:0]    lines_full, ridx_line;
  logic             cfg_bad, wr_acc, rd_acc, is_wrap, job_end;

  // Line count is ceil(N/R) without forming N+R-1, which could overflow.
  assign lines_full = (prod_q >> RSH) + PW'(|prod_q[RSH-1:0]);
  assign cfg_bad    = (prod_q == '0) || (lines_full > PW'(DEPTH));
  assign ridx_line  = ridx_q >> RSH;

  assign wr_ready_o = (state_q == S_RUN) && (PW'(wcnt_q) < lines_q) && !start_i;
  // Only the first pass can outrun the writer; later passes see all lines.
  assign rd_empty_o = (state_q != S_RUN) ||
                      ((pass_q == '0) && (ridx_line >= PW'(wcnt_q)));

  assign wr_acc  = wr_valid_i && wr_ready_o;
  assign rd_acc  = rd_req_i && !rd_empty_o && !start_i;
  assign is_wrap = (ridx_q == last_idx_q);
  assign job_end = is_wrap && (pass_q == rep_q - CNT_W'(1));

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_last_o  = rd_last_q;
  assign done_o     = done_q;
  assign cfg_err_o  = cfg_err_q;
  assign state_o    = state_q;
  // The FSM leaves RUN when the last word is accepted; busy stays up until
  // that word reaches the output so it falls together with done.
  assign busy_o     = (state_q == S_CFG) || (state_q == S_RUN) ||
                      (s1_valid_q && s1_last_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_CFG:  if (cfg_step_q) state_d = cfg_bad ? S_ERR : S_RUN;
      S_RUN:  if (rd_acc && job_end) state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (start_i) state_d = S_CFG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cfg_step_q <= 1'b0;
      rows_q     <= '0;
      cols_q     <= '0;
      rep_q      <= '0;
      pass_q     <= '0;
      prod_q     <= '0;
      lines_q    <= '0;
      last_idx_q <= '0;
      ridx_q     <= '0;
      wcnt_q     <= '0;
      cfg_err_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_word_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_i) begin
        // New job or abort: clear pointers and flush the read pipe.
        rows_q     <= cfg_rows_i;
        cols_q     <= cfg_cols_i;
        rep_q      <= (cfg_repeat_i == '0) ? CNT_W'(1) : cfg_repeat_i;
        cfg_step_q <= 1'b0;
        pass_q     <= '0;
        ridx_q     <= '0;
        wcnt_q     <= '0;
        cfg_err_q  <= 1'b0;
        s1_valid_q <= 1'b0;
        s1_last_q  <= 1'b0;
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        if (state_q == S_CFG) begin
          if (!cfg_step_q) begin
            prod_q     <= PW'(rows_q) * PW'(cols_q);
            cfg_step_q <= 1'b1;
          end else begin
            lines_q    <= lines_full;
            last_idx_q <= prod_q - PW'(1);
            cfg_err_q  <= cfg_bad;
            cfg_step_q <= 1'b0;
          end
        end
        if (wr_acc) wcnt_q <= wcnt_q + (AW+1)'(1);
        if (rd_acc) begin
          if (is_wrap) begin
            ridx_q <= '0;
            pass_q <= pass_q + CNT_W'(1);
          end else begin
            ridx_q <= ridx_q + PW'(1);
          end
        end
        s1_valid_q <= rd_acc;
        s1_last_q  <= rd_acc && job_end;
        s1_word_q  <= ridx_q[RSH-1:0];
        rd_valid_q <= s1_valid_q;
        rd_last_q  <= s1_valid_q && s1_last_q;
        done_q     <= s1_valid_q && s1_last_q;
        if (s1_valid_q) rd_data_q <= rd_line_q[s1_word_q*RD_W +: RD_W];
      end
    end
  end

  // Line storage and its registered read port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wcnt_q[AW-1:0]] <= wr_data_i;
    if (rd_acc) rd_line_q <= mem[ridx_line[AW-1:0]];
  end

endmodule

// File: tb/tb_replay_buffer_param.sv
module tb_replay_buffer_param;

  localparam int WR_W  = 1024;
  localparam int RD_W  = 32;
  localparam int DEPTH = 512;
  localparam int CNT_W = 16;
  localparam int R     = WR_W / RD_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [CNT_W-1:0] cfg_rows = '0, cfg_cols = '0, cfg_repeat = '0;
  logic [WR_W-1:0]  wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic             rd_req = 1'b0;
  logic             rd_empty, rd_valid, rd_last, busy, done, cfg_err;
  logic [RD_W-1:0]  rd_data;
  logic [1:0]       state;

  replay_buffer_param #(.WR_W(WR_W), .RD_W(RD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .cfg_rows_i(cfg_rows), .cfg_cols_i(cfg_cols), .cfg_repeat_i(cfg_repeat),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_req_i(rd_req), .rd_empty_o(rd_empty), .rd_valid_o(rd_valid),
    .rd_data_o(rd_data), .rd_last_o(rd_last), .busy_o(busy), .done_o(done),
    .cfg_err_o(cfg_err), .state_o(state)
  );

  // ---------------- reference model state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int beat_cnt = 0;
  int acc_cnt = 0;
  int job_n, job_l, job_rep;
  logic [RD_W-1:0] ref_w [DEPTH*R];
  logic [RD_W:0]   exp_q [$];   // {last, data}
  int              acc_q [$];   // cycle of each accepted read

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_req && !rd_empty && !start) begin
        acc_q.push_back(cyc);
        acc_cnt++;
      end
      if (rd_valid) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          logic [RD_W:0] e;
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e[RD_W-1:0]);
          chk("rd_last", rd_last, e[RD_W]);
          chk("done", done, e[RD_W]);
        end
        if (acc_q.size() != 0) chk("latency", cyc - acc_q.pop_front(), 2);
        else chk("beat_without_req", 1, 0);
      end else begin
        if (done) chk("stray_done", done, 0);
        if (rd_last) chk("stray_last", rd_last, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [WR_W-1:0] build_line(input int k);
    logic [WR_W-1:0] l;
    for (int j = 0; j < R; j++) l[j*RD_W +: RD_W] = ref_w[k*R + j];
    return l;
  endfunction

  task automatic start_job(input int rows, input int cols, input int rep);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_rows = CNT_W'(rows); cfg_cols = CNT_W'(cols); cfg_repeat = CNT_W'(rep);
    @(posedge clk); #1;
    start = 1'b0;
    // Model of the new job, built once the DUT has taken the start.
    exp_q.delete();
    acc_q.delete();
    beat_cnt = 0;
    acc_cnt  = 0;
    job_n   = rows * cols;
    job_l   = (job_n + R - 1) / R;
    job_rep = (rep == 0) ? 1 : rep;
    if (job_n != 0 && job_l <= DEPTH) begin
      for (int i = 0; i < job_l * R; i++) ref_w[i] = $urandom;
      for (int p = 0; p < job_rep; p++)
        for (int i = 0; i < job_n; i++)
          exp_q.push_back({(p == job_rep - 1) && (i == job_n - 1), ref_w[i]});
    end
  endtask

  task automatic write_one(input int k);
    int t;
    t = 0;
    @(posedge clk); #1;
    wr_valid = 1'b1;
    wr_data  = build_line(k);
    @(negedge clk);
    while (!wr_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("wr_accept_in_time", t < 2000, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_in_time"}, t < budget, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_empty_end"}, rd_empty, 1);
    chk({tag, "_beats"}, beat_cnt, job_n * job_rep);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_rd_empty"}, rd_empty, 1);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  task automatic run_test1(input string tag);
    start_job(4, 64, 3);
    for (int k = 0; k < job_l; k++) write_one(k);
    @(negedge clk);
    chk({tag, "_wr_ready_full"}, wr_ready, 0);
    @(posedge clk); #1 rd_req = 1'b1;
    wait_done(3000, tag);
    rd_req = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // 1. all lines first, three passes
    run_test1("t1");

    // 2. read-while-write, one line every 40 cycles
    start_job(4, 64, 3);
    @(posedge clk); #1 rd_req = 1'b1;
    for (int k = 0; k < job_l; k++) begin
      write_one(k);
      if (k != job_l - 1) begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t2_stall_words", acc_cnt, (k + 1) * R);
        chk("t2_stall_empty", rd_empty, 1);
      end
    end
    wait_done(3000, "t2");
    rd_req = 1'b0;

    // 3. partial last line
    start_job(3, 25, 2);
    for (int k = 0; k < job_l; k++) write_one(k);
    @(negedge clk);
    chk("t3_wr_ready_after_3", wr_ready, 0);
    @(posedge clk); #1 rd_req = 1'b1;
    wait_done(1000, "t3");
    rd_req = 1'b0;

    // 4. configuration errors
    start_job(0, 5, 1);
    repeat (5) @(negedge clk);
    chk("t4_zero_err", cfg_err, 1);
    chk("t4_zero_busy", busy, 0);
    chk("t4_zero_wr_ready", wr_ready, 0);
    start_job(256, 256, 1);
    repeat (5) @(negedge clk);
    chk("t4_big_err", cfg_err, 1);
    chk("t4_big_busy", busy, 0);
    start_job(1, 40, 1);
    @(negedge clk);
    chk("t4_err_cleared", cfg_err, 0);
    chk("t4_busy_cfg", busy, 1);
    for (int k = 0; k < job_l; k++) write_one(k);
    @(posedge clk); #1 rd_req = 1'b1;
    wait_done(500, "t4");
    rd_req = 1'b0;

    // 5. abort mid pass 2 with reads active
    start_job(4, 64, 3);
    for (int k = 0; k < job_l; k++) write_one(k);
    @(posedge clk); #1 rd_req = 1'b1;
    begin
      int t;
      t = 0;
      while (beat_cnt < 356 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      chk("t5_reach_pass2", t < 2000, 1);
    end
    start_job(2, 32, 1);
    @(negedge clk);
    chk("t5_flush_0", rd_valid, 0);
    @(negedge clk);
    chk("t5_flush_1", rd_valid, 0);
    for (int k = 0; k < job_l; k++) write_one(k);
    wait_done(500, "t5");
    rd_req = 1'b0;

    // random jobs: random shape, write gaps and read requests
    for (int r = 0; r < 3; r++) begin
      start_job($urandom_range(1, 8), $urandom_range(1, 40), $urandom_range(0, 3));
      fork
        begin
          for (int k = 0; k < job_l; k++) begin
            write_one(k);
            repeat ($urandom_range(0, 6)) @(posedge clk);
          end
        end
        begin
          int t;
          t = 0;
          while (exp_q.size() != 0 && t < 20000) begin
            @(posedge clk); #1 rd_req = 1'($urandom_range(0, 1));
            t++;
          end
        end
      join
      rd_req = 1'b0;
      wait_done(200, "rnd");
    end

    // 6. asynchronous reset mid-job
    start_job(4, 64, 3);
    for (int k = 0; k < job_l; k++) write_one(k);
    @(posedge clk); #1 rd_req = 1'b1;
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    rd_req = 1'b0;
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_test1("t6_rerun");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
